// File: rtl/sudoku_pkg.sv
// Shared constants and types for the sudoku board loader.
//   N_DIM    : rows/columns/digits per board side
//   N_CELLS  : cells per board
//   CELL_W   : one-hot candidate mask width per cell
//   HEX_W    : width of an incoming digit
//   BOARD_W  : width of the assembled board image
//   state_e  : loader FSM states
package sudoku_pkg;

    localparam int N_DIM   = 9;
    localparam int N_CELLS = 81;
    localparam int CELL_W  = 9;
    localparam int HEX_W   = 4;
    localparam int BOARD_W = 729;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_e;

endpackage

// File: rtl/sudoku_hex2bin_loader_hex2bin.sv
// Combinational digit-to-one-hot candidate encoder.
//   digit_i  : 0 = empty cell, 1..9 = fixed value, 10..15 = illegal
//   onehot_o : 9-bit candidate mask, digit d sets bit d-1
//   err_o    : high for an illegal digit (10..15)
// EMPTY_ALL selects whether an empty cell means "every candidate open"
// (all ones) or "no information" (all zeros).
import sudoku_pkg::*;

module hex2bin #(
    parameter bit EMPTY_ALL = 1'b0
) (
    input  logic [HEX_W-1:0]  digit_i,
    output logic [CELL_W-1:0] onehot_o,
    output logic              err_o
);

    always_comb begin
        onehot_o = '0;
        err_o    = 1'b0;
        if (digit_i == '0) begin
            onehot_o = EMPTY_ALL ? {CELL_W{1'b1}} : {CELL_W{1'b0}};
        end else if (digit_i <= 4'd9) begin
            onehot_o = CELL_W'(1) << (digit_i - 4'd1);
        end else begin
            err_o = 1'b1;
        end
    end

endmodule

// File: rtl/sudoku_hex2bin_loader.sv
// Serial puzzle loader: collects 81 digits (cell 0 first), encodes each to
// a one-hot candidate mask and presents the assembled 729-bit board.
//   clk, rst_n              : clock, asynchronous active-low reset
//   flush                   : synchronous abort of partial or held board
//   digit_valid/digit_ready : input digit handshake, digit_in carries data
//   board_valid/board_ready : output board handshake
//   board_bin               : cell i at bits [i*9+8:i*9]
//   board_err               : held board contained a digit > 9
//   cell_count              : digits accepted for the current board
import sudoku_pkg::*;

module sudoku_hex2bin_loader #(
    parameter int N_CELLS   = 81,
    parameter bit EMPTY_ALL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               digit_valid,
    output logic               digit_ready,
    input  logic [HEX_W-1:0]   digit_in,
    output logic               board_valid,
    input  logic               board_ready,
    output logic [BOARD_W-1:0] board_bin,
    output logic               board_err,
    output logic [6:0]         cell_count
);

    localparam logic [6:0] LAST_CELL = 7'(N_CELLS - 1);

    state_e             state_q, state_d;
    logic [6:0]         cellCount_q, cellCount_d;
    logic [BOARD_W-1:0] board_q, board_d;
    logic               errAcc_q, errAcc_d;
    logic               boardErr_q, boardErr_d;
    logic               boardValid_q, boardValid_d;
    logic               digitReady_q, digitReady_d;

    logic [CELL_W-1:0]  cellBits;
    logic               cellErr;
    logic               digitAccept;

    hex2bin #(
        .EMPTY_ALL (EMPTY_ALL)
    ) u_hex2bin (
        .digit_i  (digit_in),
        .onehot_o (cellBits),
        .err_o    (cellErr)
    );

    assign digitAccept = digit_valid & digitReady_q;

    // Next-state logic. flush overrides every handshake; the shift register
    // is deliberately never cleared because new digits overwrite it anyway.
    // Handshake outputs are computed one cycle ahead so they come straight
    // from flops.
    always_comb begin
        state_d      = state_q;
        cellCount_d  = cellCount_q;
        board_d      = board_q;
        errAcc_d     = errAcc_q;
        boardErr_d   = boardErr_q;
        boardValid_d = boardValid_q;
        digitReady_d = digitReady_q;

        if (flush) begin
            state_d      = LOAD;
            cellCount_d  = '0;
            errAcc_d     = 1'b0;
            boardErr_d   = 1'b0;
            boardValid_d = 1'b0;
            digitReady_d = 1'b1;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (digitAccept) begin
                        board_d     = {cellBits, board_q[BOARD_W-1:CELL_W]};
                        cellCount_d = cellCount_q + 7'd1;
                        errAcc_d    = errAcc_q | cellErr;
                        if (cellCount_q == LAST_CELL) begin
                            state_d      = FULL;
                            boardErr_d   = errAcc_q | cellErr;
                            boardValid_d = 1'b1;
                            digitReady_d = 1'b0;
                        end
                    end
                end
                FULL: begin
                    // No same-cycle turnaround: ready only returns next cycle.
                    if (board_ready) begin
                        state_d      = LOAD;
                        cellCount_d  = '0;
                        errAcc_d     = 1'b0;
                        boardValid_d = 1'b0;
                        digitReady_d = 1'b1;
                    end
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            cellCount_q  <= '0;
            board_q      <= '0;
            errAcc_q     <= 1'b0;
            boardErr_q   <= 1'b0;
            boardValid_q <= 1'b0;
            digitReady_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cellCount_q  <= cellCount_d;
            board_q      <= board_d;
            errAcc_q     <= errAcc_d;
            boardErr_q   <= boardErr_d;
            boardValid_q <= boardValid_d;
            digitReady_q <= digitReady_d;
        end
    end

    assign digit_ready = digitReady_q;
    assign board_valid = boardValid_q;
    assign board_bin   = board_q;
    assign board_err   = boardErr_q;
    assign cell_count  = cellCount_q;

endmodule

// File: tb/tb_sudoku_hex2bin_loader.sv
// Directed self-checking bench for sudoku_hex2bin_loader. Two instances
// share all inputs: dut0 with EMPTY_ALL=0 and dut1 with EMPTY_ALL=1.
module tb_sudoku_hex2bin_loader;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         digit_valid;
    logic [3:0]   digit_in;
    logic         board_ready;

    logic         digitReady0, digitReady1;
    logic         boardValid0, boardValid1;
    logic [728:0] boardBin0, boardBin1;
    logic         boardErr0, boardErr1;
    logic [6:0]   cellCount0, cellCount1;

    int testsRun;
    int testsFailed;

    logic [3:0]   cur[81];
    logic [728:0] expBoard;

    sudoku_hex2bin_loader #(.N_CELLS(81), .EMPTY_ALL(1'b0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .digit_valid (digit_valid),
        .digit_ready (digitReady0),
        .digit_in    (digit_in),
        .board_valid (boardValid0),
        .board_ready (board_ready),
        .board_bin   (boardBin0),
        .board_err   (boardErr0),
        .cell_count  (cellCount0)
    );

    sudoku_hex2bin_loader #(.N_CELLS(81), .EMPTY_ALL(1'b1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .digit_valid (digit_valid),
        .digit_ready (digitReady1),
        .digit_in    (digit_in),
        .board_valid (boardValid1),
        .board_ready (board_ready),
        .board_bin   (boardBin1),
        .board_err   (boardErr1),
        .cell_count  (cellCount1)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [728:0] observed,
                               input logic [728:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Fill cur[] with the solved reference board.
    task automatic loadSolved();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                cur[r*9+c] = 4'(((r*3 + r/3 + c) % 9) + 1);
    endtask

    // Reference encoding of cur[] into a board image.
    function automatic logic [728:0] buildExpected(input bit emptyAll);
        logic [728:0] b;
        logic [8:0]   m;
        b = '0;
        for (int i = 0; i < 81; i++) begin
            if (cur[i] == 4'd0)      m = emptyAll ? 9'h1FF : 9'h000;
            else if (cur[i] <= 4'd9) m = 9'h001 << (cur[i] - 4'd1);
            else                     m = 9'h000;
            b[i*9 +: 9] = m;
        end
        return b;
    endfunction

    // Stream the first n digits of cur[] back-to-back, ending #1 after the
    // last accepting edge. Before the 81st digit, checks the loader is still
    // collecting.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 80) begin
                checkOutput("pre_last_valid", 729'(boardValid0), 729'(1'b0));
                checkOutput("pre_last_count", 729'(cellCount0), 729'(80));
            end
            digit_valid = 1'b1;
            digit_in    = cur[i];
            @(posedge clk);
            #1;
            if (i == 0)
                checkOutput("count_after_first", 729'(cellCount0), 729'(1));
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        digit_valid = 1'b0;
        digit_in    = 4'd0;
        board_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_count", 729'(cellCount0), 729'(0));
        checkOutput("rst_board", boardBin0, '0);
        checkOutput("rst_valid", 729'(boardValid0), 729'(0));
        checkOutput("rst_err", 729'(boardErr0), 729'(0));
        rst_n = 1'b1;
        #1;
        checkOutput("rst_ready", 729'(digitReady0), 729'(1));

        // Solved board, consumer always ready
        loadSolved();
        expBoard = buildExpected(1'b0);
        applyStimulus(81);
        digit_valid = 1'b0;
        checkOutput("s1_valid", 729'(boardValid0), 729'(1));
        checkOutput("s1_count", 729'(cellCount0), 729'(81));
        checkOutput("s1_ready", 729'(digitReady0), 729'(0));
        checkOutput("s1_board", boardBin0, expBoard);
        checkOutput("s1_cell0", 729'(boardBin0[8:0]), 729'(9'h001));
        checkOutput("s1_cell1", 729'(boardBin0[17:9]), 729'(9'h002));
        // Cell 80 (r8,c8): (24+2+8)%9+1 = 8
        checkOutput("s1_cell80", 729'(boardBin0[728:720]), 729'(9'h080));
        checkOutput("s1_err", 729'(boardErr0), 729'(0));
        @(posedge clk);
        #1;
        checkOutput("s1_valid_drop", 729'(boardValid0), 729'(0));
        checkOutput("s1_ready_back", 729'(digitReady0), 729'(1));
        checkOutput("s1_count_clr", 729'(cellCount0), 729'(0));

        // Back-pressure: consumer stalls 10 cycles while digits keep coming
        board_ready = 1'b0;
        applyStimulus(81);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_ready", 729'(digitReady0), 729'(0));
            checkOutput("bp_valid", 729'(boardValid0), 729'(1));
            checkOutput("bp_board", boardBin0, expBoard);
            checkOutput("bp_count", 729'(cellCount0), 729'(81));
        end
        board_ready = 1'b1;
        digit_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bp_valid_drop", 729'(boardValid0), 729'(0));
        checkOutput("bp_ready_back", 729'(digitReady0), 729'(1));
        checkOutput("bp_count_clr", 729'(cellCount0), 729'(0));
        checkOutput("bp_board_kept", boardBin0, expBoard);

        // All-empty board under both empty encodings
        for (int i = 0; i < 81; i++) cur[i] = 4'd0;
        applyStimulus(81);
        digit_valid = 1'b0;
        checkOutput("empty0_board", boardBin0, '0);
        checkOutput("empty1_board", boardBin1, {729{1'b1}});
        checkOutput("empty1_valid", 729'(boardValid1), 729'(1));
        checkOutput("empty_err", 729'(boardErr0), 729'(0));
        @(posedge clk);
        #1;

        // Illegal digit at cell 40, then a clean board clears the error
        loadSolved();
        cur[40] = 4'hC;
        expBoard = buildExpected(1'b0);
        applyStimulus(81);
        digit_valid = 1'b0;
        checkOutput("err_cell40", 729'(boardBin0[368:360]), 729'(9'h000));
        checkOutput("err_board", boardBin0, expBoard);
        checkOutput("err_flag", 729'(boardErr0), 729'(1));
        @(posedge clk);
        #1;
        loadSolved();
        expBoard = buildExpected(1'b0);
        applyStimulus(81);
        digit_valid = 1'b0;
        checkOutput("clean_err", 729'(boardErr0), 729'(0));
        checkOutput("clean_board", boardBin0, expBoard);
        @(posedge clk);
        #1;

        // Flush drops a held board even with a simultaneous board handshake
        cur[40] = 4'hC;
        board_ready = 1'b0;
        applyStimulus(81);
        digit_valid = 1'b0;
        checkOutput("fh_err_set", 729'(boardErr0), 729'(1));
        flush = 1'b1;
        board_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("fh_valid", 729'(boardValid0), 729'(0));
        checkOutput("fh_err_clr", 729'(boardErr0), 729'(0));
        checkOutput("fh_ready", 729'(digitReady0), 729'(1));
        checkOutput("fh_count", 729'(cellCount0), 729'(0));

        // Flush mid-board together with a digit accept
        loadSolved();
        applyStimulus(50);
        checkOutput("fl_count50", 729'(cellCount0), 729'(50));
        digit_valid = 1'b1;
        digit_in    = 4'd5;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        digit_valid = 1'b0;
        checkOutput("fl_count", 729'(cellCount0), 729'(0));
        checkOutput("fl_valid", 729'(boardValid0), 729'(0));
        expBoard = buildExpected(1'b0);
        applyStimulus(81);
        digit_valid = 1'b0;
        checkOutput("fl_full_board", boardBin0, expBoard);
        checkOutput("fl_full_count", 729'(cellCount0), 729'(81));
        checkOutput("fl_full_valid", 729'(boardValid0), 729'(1));
        @(posedge clk);
        #1;

        // Asynchronous reset mid-board at cell 30
        applyStimulus(30);
        digit_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_count", 729'(cellCount0), 729'(0));
        checkOutput("ar_board", boardBin0, '0);
        checkOutput("ar_valid", 729'(boardValid0), 729'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ar_ready", 729'(digitReady0), 729'(1));
        applyStimulus(81);
        digit_valid = 1'b0;
        checkOutput("ar_full_board", boardBin0, expBoard);
        checkOutput("ar_full_valid", 729'(boardValid0), 729'(1));
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
